// File: rtl/ula_seq.sv
// ula_seq: registered ALU with single-cycle logic/arith/shift ops and an
// iterative shift-add multiplier (one multiplier bit per clock).
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_ula,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int             CW      = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LP_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] LP_WVAL = WIDTH'(WIDTH);

  typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_mul_start, w_alu_wr, w_mul_fin;

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   r_out;
  logic               r_carry, r_zero, r_neg, r_ovf, r_done;

  logic [WIDTH:0]     w_sum, w_diff, w_shl, w_shr, w_step;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v;

  // State register; reset wins over everything, including an in-flight MUL.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and datapath strobes. start is only looked at while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_alu_wr    = 1'b0;
    w_mul_fin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            w_mul_start = 1'b1;
            w_state_nxt = S_MUL_RUN;
          end else begin
            w_alu_wr = 1'b1;
          end
        end
      end
      S_MUL_RUN: begin
        if (r_cnt == LP_LAST) begin
          w_mul_fin   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  // One guard bit on the side the bits leave from holds the last bit shifted out.
  assign w_shl  = {1'b0, a} << b;
  assign w_shr  = {a, 1'b0} >> b;

  // Single-cycle result and carry/overflow; undefined opcodes fall to zero.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_NOT: w_res = ~b;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin
        if (b == '0) begin
          w_res = a;
        end else if (b < LP_WVAL) begin
          w_res = w_shl[WIDTH-1:0];
          w_c   = w_shl[WIDTH];
        end
      end
      OP_SHR: begin
        if (b == '0) begin
          w_res = a;
        end else if (b < LP_WVAL) begin
          w_res = w_shr[WIDTH:1];
          w_c   = w_shr[0];
        end
      end
      default: ;
    endcase
  end

  // Shift-add step: upper half accumulates, lower half holds remaining multiplier bits.
  assign w_step     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_step, r_prod[WIDTH-1:1]};

  // Multiplier operand/partial-product/iteration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (w_mul_start) begin
      r_mcand <= a;
      r_prod  <= {{WIDTH{1'b0}}, b};
      r_cnt   <= '0;
    end else if (r_state == S_MUL_RUN && !w_mul_fin) begin
      r_prod  <= w_prod_nxt;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result/flag registers hold between ops; done is a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_alu_wr) begin
        r_out   <= w_res;
        r_carry <= w_c;
        r_ovf   <= w_v;
        r_zero  <= (w_res == '0);
        r_neg   <= w_res[WIDTH-1];
        r_done  <= 1'b1;
      end else if (w_mul_fin) begin
        r_out   <= w_prod_nxt[WIDTH-1:0];
        r_carry <= |w_prod_nxt[2*WIDTH-1:WIDTH];
        r_ovf   <= 1'b0;
        r_zero  <= (w_prod_nxt[WIDTH-1:0] == '0);
        r_neg   <= w_prod_nxt[WIDTH-1];
        r_done  <= 1'b1;
      end
    end
  end

  assign busy    = (r_state == S_MUL_RUN);
  assign done    = r_done;
  assign out_ula = r_out;
  assign carry   = r_carry;
  assign zero    = r_zero;
  assign neg     = r_neg;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq at WIDTH=8. Observed bundle is
// {busy, done, out_ula, carry, zero, neg, ovf}.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a, b;
  logic [3:0] op;
  logic       busy, done, carry, zero, neg, ovf;
  logic [7:0] out_ula;
  logic [13:0] obs;

  int n_vec = 0;
  int n_err = 0;

  ula_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .out_ula(out_ula),
    .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, out_ula, carry, zero, neg, ovf};

  // Present one op at the falling edge, let one rising edge take it, then drop start.
  task automatic drive(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 4'd1; a = 8'h02; b = 8'h03;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (obs !== 14'b0) begin n_err++; $display("FAIL reset_state got %b exp %b", obs, 14'b0); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    n_vec++; if (obs !== {2'b01, 8'h05, 4'b0000}) begin n_err++; $display("FAIL first_accept got %b exp %b", obs, {2'b01, 8'h05, 4'b0000}); end
  endtask

  task automatic test_add;
    drive(4'd1, 8'hFF, 8'h01);
    n_vec++; if (obs !== {2'b01, 8'h00, 4'b1100}) begin n_err++; $display("FAIL add_ff_01 got %b exp %b", obs, {2'b01, 8'h00, 4'b1100}); end
    @(posedge clk); #1;
    n_vec++; if (obs !== {2'b00, 8'h00, 4'b1100}) begin n_err++; $display("FAIL add_hold got %b exp %b", obs, {2'b00, 8'h00, 4'b1100}); end
    drive(4'd1, 8'h7F, 8'h01);
    n_vec++; if (obs !== {2'b01, 8'h80, 4'b0011}) begin n_err++; $display("FAIL add_ovf got %b exp %b", obs, {2'b01, 8'h80, 4'b0011}); end
  endtask

  task automatic test_sub;
    drive(4'd2, 8'h80, 8'h01);
    n_vec++; if (obs !== {2'b01, 8'h7F, 4'b0001}) begin n_err++; $display("FAIL sub_80_01 got %b exp %b", obs, {2'b01, 8'h7F, 4'b0001}); end
    drive(4'd2, 8'h01, 8'h02);
    n_vec++; if (obs !== {2'b01, 8'hFF, 4'b1010}) begin n_err++; $display("FAIL sub_borrow got %b exp %b", obs, {2'b01, 8'hFF, 4'b1010}); end
  endtask

  task automatic test_logic;
    drive(4'd3, 8'hF0, 8'h3C);
    n_vec++; if (obs !== {2'b01, 8'h30, 4'b0000}) begin n_err++; $display("FAIL and got %b exp %b", obs, {2'b01, 8'h30, 4'b0000}); end
    drive(4'd4, 8'hF0, 8'h0F);
    n_vec++; if (obs !== {2'b01, 8'hFF, 4'b0010}) begin n_err++; $display("FAIL or got %b exp %b", obs, {2'b01, 8'hFF, 4'b0010}); end
    drive(4'd5, 8'h55, 8'h0F);
    n_vec++; if (obs !== {2'b01, 8'hF0, 4'b0010}) begin n_err++; $display("FAIL not got %b exp %b", obs, {2'b01, 8'hF0, 4'b0010}); end
    drive(4'd6, 8'hAA, 8'hAA);
    n_vec++; if (obs !== {2'b01, 8'h00, 4'b0100}) begin n_err++; $display("FAIL xor got %b exp %b", obs, {2'b01, 8'h00, 4'b0100}); end
  endtask

  task automatic test_shift;
    drive(4'd7, 8'h81, 8'd1);
    n_vec++; if (obs !== {2'b01, 8'h02, 4'b1000}) begin n_err++; $display("FAIL shl_1 got %b exp %b", obs, {2'b01, 8'h02, 4'b1000}); end
    drive(4'd8, 8'h81, 8'd8);
    n_vec++; if (obs !== {2'b01, 8'h00, 4'b0100}) begin n_err++; $display("FAIL shr_8 got %b exp %b", obs, {2'b01, 8'h00, 4'b0100}); end
    drive(4'd8, 8'h81, 8'd1);
    n_vec++; if (obs !== {2'b01, 8'h40, 4'b1000}) begin n_err++; $display("FAIL shr_1 got %b exp %b", obs, {2'b01, 8'h40, 4'b1000}); end
    drive(4'd7, 8'h81, 8'd0);
    n_vec++; if (obs !== {2'b01, 8'h81, 4'b0010}) begin n_err++; $display("FAIL shl_0 got %b exp %b", obs, {2'b01, 8'h81, 4'b0010}); end
    drive(4'd7, 8'h81, 8'd7);
    n_vec++; if (obs !== {2'b01, 8'h80, 4'b0010}) begin n_err++; $display("FAIL shl_7a got %b exp %b", obs, {2'b01, 8'h80, 4'b0010}); end
    drive(4'd7, 8'h03, 8'd7);
    n_vec++; if (obs !== {2'b01, 8'h80, 4'b1010}) begin n_err++; $display("FAIL shl_7b got %b exp %b", obs, {2'b01, 8'h80, 4'b1010}); end
    drive(4'd7, 8'h81, 8'd200);
    n_vec++; if (obs !== {2'b01, 8'h00, 4'b0100}) begin n_err++; $display("FAIL shl_big got %b exp %b", obs, {2'b01, 8'h00, 4'b0100}); end
  endtask

  task automatic test_undef;
    drive(4'd1, 8'h7F, 8'h81);  // leaves carry=1, neg=0: 0x00, c1 z1
    drive(4'hF, 8'hFF, 8'hFF);
    n_vec++; if (obs !== {2'b01, 8'h00, 4'b0100}) begin n_err++; $display("FAIL undef_f got %b exp %b", obs, {2'b01, 8'h00, 4'b0100}); end
    drive(4'd1, 8'h7F, 8'h01);  // 0x80, n1 v1
    drive(4'h0, 8'hFF, 8'hFF);
    n_vec++; if (obs !== {2'b01, 8'h00, 4'b0100}) begin n_err++; $display("FAIL undef_0 got %b exp %b", obs, {2'b01, 8'h00, 4'b0100}); end
  endtask

  task automatic test_back_to_back;
    drive(4'd1, 8'h01, 8'h01);
    n_vec++; if (obs !== {2'b01, 8'h02, 4'b0000}) begin n_err++; $display("FAIL b2b_0 got %b exp %b", obs, {2'b01, 8'h02, 4'b0000}); end
    drive(4'd6, 8'h0F, 8'h01);
    n_vec++; if (obs !== {2'b01, 8'h0E, 4'b0000}) begin n_err++; $display("FAIL b2b_1 got %b exp %b", obs, {2'b01, 8'h0E, 4'b0000}); end
    drive(4'd4, 8'h30, 8'h03);
    n_vec++; if (obs !== {2'b01, 8'h33, 4'b0000}) begin n_err++; $display("FAIL b2b_2 got %b exp %b", obs, {2'b01, 8'h33, 4'b0000}); end
    @(posedge clk); #1;
    n_vec++; if (obs !== {2'b00, 8'h33, 4'b0000}) begin n_err++; $display("FAIL b2b_idle got %b exp %b", obs, {2'b00, 8'h33, 4'b0000}); end
  endtask

  task automatic test_mul;
    logic ok;
    // 0x10*0x20 = 0x200; an ADD offered during the run must be dropped.
    drive(4'd9, 8'h10, 8'h20);
    n_vec++; if (obs !== {2'b10, 8'h33, 4'b0000}) begin n_err++; $display("FAIL mul_accept got %b exp %b", obs, {2'b10, 8'h33, 4'b0000}); end
    ok = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin
        @(negedge clk); start = 1'b1; op = 4'd1; a = 8'h01; b = 8'h01;
      end
      @(posedge clk); #1; start = 1'b0;
      if (obs !== {2'b10, 8'h33, 4'b0000}) ok = 1'b0;
    end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL mul_running got %b exp %b", ok, 1'b1); end
    @(posedge clk); #1;
    n_vec++; if (obs !== {2'b01, 8'h00, 4'b1100}) begin n_err++; $display("FAIL mul_10_20 got %b exp %b", obs, {2'b01, 8'h00, 4'b1100}); end
    @(posedge clk); #1;
    n_vec++; if (obs !== {2'b00, 8'h00, 4'b1100}) begin n_err++; $display("FAIL mul_after got %b exp %b", obs, {2'b00, 8'h00, 4'b1100}); end

    drive(4'd9, 8'h0F, 8'h0F);
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (obs !== {2'b01, 8'hE1, 4'b0010}) begin n_err++; $display("FAIL mul_0f_0f got %b exp %b", obs, {2'b01, 8'hE1, 4'b0010}); end
    drive(4'd9, 8'hFF, 8'hFF);
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (obs !== {2'b01, 8'h01, 4'b1000}) begin n_err++; $display("FAIL mul_ff_ff got %b exp %b", obs, {2'b01, 8'h01, 4'b1000}); end
    drive(4'd9, 8'h0D, 8'h0B);
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (obs !== {2'b01, 8'h8F, 4'b0010}) begin n_err++; $display("FAIL mul_0d_0b got %b exp %b", obs, {2'b01, 8'h8F, 4'b0010}); end
  endtask

  task automatic test_mul_reset;
    logic saw_done;
    drive(4'd1, 8'h01, 8'h06);
    drive(4'd9, 8'h0F, 8'h0F);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (obs !== 14'b0) begin n_err++; $display("FAIL mul_abort got %b exp %b", obs, 14'b0); end
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL mul_abort_quiet got %b exp %b", saw_done, 1'b0); end
    drive(4'd1, 8'h02, 8'h03);
    n_vec++; if (obs !== {2'b01, 8'h05, 4'b0000}) begin n_err++; $display("FAIL add_after_abort got %b exp %b", obs, {2'b01, 8'h05, 4'b0000}); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00;
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_shift;
    test_undef;
    test_back_to_back;
    test_mul;
    test_mul_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
